// File: rtl/secded_stream_decoder.sv
// ---------------------------------------------------------------------------
// secded_stream_decoder
//
// Pipelined SECDED (extended Hamming) decoder with a valid/ready stream
// interface, a registered syndrome and saturating error-event counters.
// It sits on the receive side of a memory or link path.
//
// Parameters
//   DATA_W  number of data bits (1..57)
//   CNT_W   width of each error counter
//   P       number of Hamming check bits (derived)
//   CW      codeword width, DATA_W + P + 1 (derived)
//
// Ports
//   clk                rising-edge clock
//   rstn               asynchronous active-low reset
//   in_valid/in_ready  input handshake for code_in
//   code_in            bit i (i < CW-1) is Hamming position i+1,
//                      bit CW-1 is the overall even-parity bit
//   out_valid/out_ready output handshake for the decoded result
//   data_out           data bits from the non-power-of-two positions,
//                      ascending position -> ascending bit index
//   syndrome_out       Hamming syndrome of the delivered word
//   err_correctable    single-bit error found and corrected
//   err_uncorrectable  double or out-of-range error found
//   cnt_clr            synchronous clear of both counters
//   cnt_corr           saturating count of delivered correctable words
//   cnt_uncorr         saturating count of delivered uncorrectable words
//
// Handshake: a word moves across an interface on a rising clock edge where
// valid and ready are both 1. Once a valid is raised, the payload beside it
// holds steady until that transfer happens; ready may depend combinationally
// on the downstream ready (in_ready follows out_ready).
// ---------------------------------------------------------------------------
module secded_stream_decoder #(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    // Smallest P with 2^P >= DATA_W + P + 1, over the legal DATA_W range.
    localparam int P      = (DATA_W <= 1)  ? 2 :
                            (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 : 6,
    localparam int CW     = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW-1:0]     code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [P-1:0]      syndrome_out,
    output logic              err_correctable,
    output logic              err_uncorrectable,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ---------------- stage control ----------------
    logic s1_valid;
    logic s2_valid;
    logic s1_load;
    logic s2_load;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = !s1_valid || !s2_valid || out_ready;

    // ---------------- syndrome / overall parity of the input ----------------
    logic [P-1:0] syn_c;
    logic         op_c;

    always_comb begin
        syn_c = '0;
        for (int k = 0; k < P; k++) begin
            for (int i = 0; i < CW - 1; i++) begin
                if ((((i + 1) >> k) & 1) == 1) begin
                    syn_c[k] = syn_c[k] ^ code_in[i];
                end
            end
        end
        op_c = ^code_in;
    end

    // ---------------- stage 1 registers ----------------
    // The overall-parity bit carries no data, so only the Hamming positions
    // are kept; its contribution already lives in s1_op.
    logic [CW-2:0] s1_code;
    logic [P-1:0]  s1_syn;
    logic          s1_op;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_op    <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= code_in[CW-2:0];
                s1_syn  <= syn_c;
                s1_op   <= op_c;
            end
        end
    end

    // ---------------- correction and extraction ----------------
    logic [CW-2:0]     flip_c;
    logic [CW-2:0]     fixed_c;
    logic [DATA_W-1:0] data_c;
    logic              in_range_c;
    logic              corr_c;
    logic              uncorr_c;

    always_comb begin
        int j;
        j = 0;
        // A syndrome beyond the last position can only occur in shortened
        // codes and points at a bit that does not exist.
        in_range_c = int'(s1_syn) <= CW - 1;
        flip_c     = '0;
        for (int i = 0; i < CW - 1; i++) begin
            flip_c[i] = s1_op && (int'(s1_syn) == i + 1);
        end
        fixed_c = s1_code ^ flip_c;
        data_c  = '0;
        for (int i = 0; i < CW - 1; i++) begin
            // Position i+1 is a data position unless it is a power of two.
            if (((i + 1) & i) != 0) begin
                if (j < DATA_W) begin
                    data_c[j] = fixed_c[i];
                end
                j = j + 1;
            end
        end
        corr_c   = s1_op && in_range_c;
        uncorr_c = s1_op ? !in_range_c : (s1_syn != '0);
    end

    // ---------------- stage 2 registers (outputs) ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid          <= 1'b0;
            data_out          <= '0;
            syndrome_out      <= '0;
            err_correctable   <= 1'b0;
            err_uncorrectable <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                data_out          <= data_c;
                syndrome_out      <= s1_syn;
                err_correctable   <= corr_c;
                err_uncorrectable <= uncorr_c;
            end
        end
    end

    assign out_valid = s2_valid;

    // ---------------- error-event counters ----------------
    logic out_fire;
    assign out_fire = s2_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (out_fire) begin
            if (err_correctable && cnt_corr != CNT_MAX) begin
                cnt_corr <= cnt_corr + CNT_W'(1);
            end
            if (err_uncorrectable && cnt_uncorr != CNT_MAX) begin
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
            end
        end
    end

endmodule
